// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package atm_pkg;

  // Session states, in the order a normal session walks through them
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LANG,
    ST_PIN,
    ST_MENU,
    ST_WITHDRAW,
    ST_DEPOSIT,
    ST_BALANCE,
    ST_EXIT
  } state_t;

  // Menu operation codes as presented on the Operation input
  localparam logic [1:0] OP_WITHDRAW = 2'd0;
  localparam logic [1:0] OP_DEPOSIT  = 2'd1;
  localparam logic [1:0] OP_BALANCE  = 2'd2;
  localparam logic [1:0] OP_EXIT     = 2'd3;

  // Defaults for the accepted PIN and the balance loaded at reset
  localparam logic [3:0] DEF_PIN_CODE     = 4'b1101;
  localparam logic [7:0] DEF_INIT_BALANCE = 8'd100;

  // Balance plus deposit, clamped at 255 instead of wrapping
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/atm_balance_unit.sv
// Account balance register with checked withdraw and saturating deposit.
// Latency: update lands one clk after the request; wd_ok is combinational.
// Backpressure: none; a withdraw larger than the balance is simply not applied.
module atm_balance_unit
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BALANCE = DEF_INIT_BALANCE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wd_req,
  input  logic       dep_req,
  input  logic [5:0] wd_amt,
  input  logic [4:0] dep_amt,
  output logic [7:0] cb,
  output logic       wd_ok
);

  logic [7:0] cb_q;
  logic [7:0] cb_d;

  // Next balance: withdraw only when covered, deposit clamps at 255
  always_comb begin
    wd_ok = ({2'b00, wd_amt} <= cb_q);
    cb_d  = cb_q;
    if (wd_req && wd_ok) begin
      cb_d = cb_q - {2'b00, wd_amt};
    end else if (dep_req) begin
      cb_d = sat_add(cb_q, dep_amt);
    end
  end

  // Balance register; only reset restores the initial balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_q <= INIT_BALANCE;
    end else begin
      cb_q <= cb_d;
    end
  end

  assign cb = cb_q;

endmodule

// File: rtl/atm_controller.sv
// ATM session FSM: card, language, PIN with retry limit, then menu operations.
// Latency: each operation completes one clk after entering its state.
// Backpressure: none; panel levels are sampled every cycle, withdraw waits for funds.
module atm_controller
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BALANCE = DEF_INIT_BALANCE,
  parameter logic [3:0] PIN_CODE     = DEF_PIN_CODE,
  parameter int         MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IC,
  input  logic       LC,
  input  logic       Ex,
  input  logic [3:0] Pin,
  input  logic [1:0] Operation,
  input  logic [5:0] WithDraw_Amount,
  input  logic [4:0] Deposit_Amount,
  input  logic       goMain,
  output logic [7:0] CB,
  output logic [7:0] FinalBalance
);

  localparam int             TW    = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]  MAX_T = TW'(MAX_TRIES);

  state_t        state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [TW-1:0] tries_inc;
  logic          armed_q, armed_d;
  logic [1:0]    last_op_q, last_op_d;
  logic [7:0]    fb_q, fb_d;

  logic          wd_req;
  logic          dep_req;
  logic          wd_ok;
  logic [7:0]    cb;

  assign tries_inc = tries_q + TW'(1);

  atm_balance_unit #(
    .INIT_BALANCE (INIT_BALANCE)
  ) u_balance (
    .clk     (clk),
    .rst_n   (rst),
    .wd_req  (wd_req),
    .dep_req (dep_req),
    .wd_amt  (WithDraw_Amount),
    .dep_amt (Deposit_Amount),
    .cb      (cb),
    .wd_ok   (wd_ok)
  );

  // Next state and per-state actions; an abort overrides the state's own action
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    armed_d   = armed_q;
    last_op_d = last_op_q;
    fb_d      = fb_q;
    wd_req    = 1'b0;
    dep_req   = 1'b0;

    if ((state_q != ST_IDLE) && Ex) begin
      state_d = ST_EXIT;
    end else if ((state_q != ST_IDLE) && !IC) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tries_d = '0;
          if (IC) state_d = ST_LANG;
        end
        ST_LANG: begin
          if (LC) state_d = ST_PIN;
        end
        ST_PIN: begin
          if (Pin == PIN_CODE) begin
            state_d = ST_MENU;
            armed_d = 1'b1;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == MAX_T) state_d = ST_IDLE;
          end
        end
        ST_MENU: begin
          // Holding the same selection must not repeat it; arming or a new code dispatches
          if (armed_q || (Operation != last_op_q) || goMain) begin
            last_op_d = Operation;
            armed_d   = 1'b0;
            case (Operation)
              OP_WITHDRAW: state_d = ST_WITHDRAW;
              OP_DEPOSIT:  state_d = ST_DEPOSIT;
              OP_BALANCE:  state_d = ST_BALANCE;
              default:     state_d = ST_EXIT;
            endcase
          end
        end
        ST_WITHDRAW: begin
          if (goMain) begin
            state_d = ST_MENU;
            armed_d = 1'b1;
          end else begin
            wd_req = 1'b1;
            if (wd_ok) state_d = ST_MENU;
          end
        end
        ST_DEPOSIT: begin
          dep_req = 1'b1;
          state_d = ST_MENU;
        end
        ST_BALANCE: begin
          fb_d    = cb;
          state_d = ST_MENU;
        end
        ST_EXIT: begin
          fb_d    = cb;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Session registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tries_q   <= '0;
      armed_q   <= 1'b0;
      last_op_q <= 2'd0;
      fb_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      armed_q   <= armed_d;
      last_op_q <= last_op_d;
      fb_q      <= fb_d;
    end
  end

  assign CB           = cb;
  assign FinalBalance = fb_q;

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: expectations queued with stimulus, drained after clocks.
module tb_atm_controller;
  import atm_pkg::*;

  localparam int K_CB = 0;
  localparam int K_FB = 1;
  localparam int K_ST = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       IC, LC, Ex, goMain;
  logic [3:0] Pin;
  logic [1:0] Operation;
  logic [5:0] WithDraw_Amount;
  logic [4:0] Deposit_Amount;
  logic [7:0] CB, FinalBalance;

  atm_controller dut (
    .clk             (clk),
    .rst             (rst),
    .IC              (IC),
    .LC              (LC),
    .Ex              (Ex),
    .Pin             (Pin),
    .Operation       (Operation),
    .WithDraw_Amount (WithDraw_Amount),
    .Deposit_Amount  (Deposit_Amount),
    .goMain          (goMain),
    .CB              (CB),
    .FinalBalance    (FinalBalance)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mdl_cb;
  logic [7:0] mdl_fb;

  int tab_op[13]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 2, 0, 1};
  int tab_amt[13] = '{31, 31, 31, 31, 31, 31, 31, 5, 31, 63, 0, 0, 5};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_CB:    return CB;
      K_FB:    return FinalBalance;
      default: return {5'b00000, dut.state_q};
    endcase
  endfunction

  task automatic push_exp(input string tag, input int kind, input logic [7:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_st(input string tag, input state_t st);
    push_exp({tag, ".state"}, K_ST, {5'b00000, st});
  endtask

  task automatic push_all(input string tag, input state_t st);
    push_exp({tag, ".cb"}, K_CB, mdl_cb);
    push_exp({tag, ".fb"}, K_FB, mdl_fb);
    push_st(tag, st);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // From IDLE with a card present: LANG, PIN, then MENU on a correct PIN
  task automatic login(input logic [3:0] p);
    IC  = 1'b1;
    LC  = 1'b1;
    Pin = p;
    step(3);
  endtask

  // One menu operation from MENU, forced to dispatch with goMain
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] amt);
    int s;
    Operation       = op;
    WithDraw_Amount = amt;
    Deposit_Amount  = amt[4:0];
    goMain          = 1'b1;
    step(1);
    goMain = 1'b0;
    case (op)
      OP_WITHDRAW: mdl_cb = mdl_cb - {2'b00, amt};
      OP_DEPOSIT: begin
        s = int'(mdl_cb) + int'(amt[4:0]);
        mdl_cb = (s > 255) ? 8'd255 : 8'(s);
      end
      OP_BALANCE: mdl_fb = mdl_cb;
      default: ;
    endcase
    step(1);
    push_all(tag, ST_MENU);
    sb_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    IC = 1'b0; LC = 1'b0; Ex = 1'b0; goMain = 1'b0;
    Pin = 4'd0; Operation = 2'd0; WithDraw_Amount = 6'd0; Deposit_Amount = 5'd0;
    mdl_cb = 8'd100;
    mdl_fb = 8'd0;

    #12;
    push_all("reset", ST_IDLE);
    sb_drain();
    @(negedge clk);
    rst = 1'b1;

    // Balance enquiry on a fresh session
    Operation = OP_BALANCE;
    login(4'd13);
    push_st("login", ST_MENU);
    sb_drain();
    step(1);
    push_st("bal_enter", ST_BALANCE);
    sb_drain();
    step(1);
    mdl_fb = mdl_cb;
    push_all("bal_done", ST_MENU);
    sb_drain();

    // Withdraw 40, then exit through the menu
    Operation = OP_WITHDRAW;
    WithDraw_Amount = 6'd40;
    step(1);
    push_st("wd_enter", ST_WITHDRAW);
    sb_drain();
    step(1);
    mdl_cb = 8'd60;
    push_exp("wd40.cb", K_CB, mdl_cb);
    push_st("wd40", ST_MENU);
    sb_drain();
    Operation = OP_EXIT;
    step(1);
    push_st("exit_enter", ST_EXIT);
    sb_drain();
    step(1);
    mdl_fb = mdl_cb;
    push_exp("exit.fb", K_FB, mdl_fb);
    push_st("exit", ST_IDLE);
    sb_drain();

    // Withdraw beyond the balance waits, goMain cancels it
    Operation = OP_WITHDRAW;
    WithDraw_Amount = 6'd63;
    login(4'd13);
    step(1);
    step(2);
    push_exp("wd63_wait.cb", K_CB, mdl_cb);
    push_st("wd63_wait", ST_WITHDRAW);
    sb_drain();
    goMain = 1'b1;
    step(1);
    goMain = 1'b0;
    push_exp("gomain.cb", K_CB, mdl_cb);
    push_st("gomain", ST_MENU);
    sb_drain();

    // Operation table: deposits up to saturation, boundary withdraws, enquiry
    do_op("dep5", OP_DEPOSIT, 6'd5);
    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("tab%0d", i), 2'(tab_op[i]), 6'(tab_amt[i]));
    end

    // Three wrong PINs eject the card; a later session gets fresh tries
    IC = 1'b0;
    step(1);
    push_st("card_out", ST_IDLE);
    sb_drain();
    IC = 1'b1;
    LC = 1'b1;
    Pin = 4'd0;
    step(4);
    push_st("pin_bad2", ST_PIN);
    sb_drain();
    step(1);
    push_st("pin_bad3", ST_IDLE);
    sb_drain();
    step(4);
    Pin = 4'd13;
    step(1);
    push_exp("relogin.cb", K_CB, mdl_cb);
    push_st("relogin", ST_MENU);
    sb_drain();

    // Ex while in WITHDRAW aborts without debiting
    Operation = OP_WITHDRAW;
    WithDraw_Amount = 6'd50;
    step(1);
    push_st("ex_wd", ST_WITHDRAW);
    sb_drain();
    Ex = 1'b1;
    step(1);
    Ex = 1'b0;
    push_exp("ex_abort.cb", K_CB, mdl_cb);
    push_st("ex_abort", ST_EXIT);
    sb_drain();
    step(1);
    mdl_fb = mdl_cb;
    push_exp("ex_done.fb", K_FB, mdl_fb);
    push_st("ex_done", ST_IDLE);
    sb_drain();

    // Asynchronous reset while in BALANCE
    Operation = OP_BALANCE;
    login(4'd13);
    step(1);
    push_st("rst_bal", ST_BALANCE);
    sb_drain();
    #2;
    rst = 1'b0;
    #1;
    mdl_cb = 8'd100;
    mdl_fb = 8'd0;
    push_all("async_rst", ST_IDLE);
    sb_drain();
    @(negedge clk);
    rst = 1'b1;

    // Deposit 5 from the restored balance
    Operation = OP_DEPOSIT;
    Deposit_Amount = 5'd5;
    login(4'd13);
    step(2);
    mdl_cb = 8'd105;
    push_all("dep_after_rst", ST_MENU);
    sb_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
